// File: rtl/i2c_slave_regfile.sv
// i2c_slave_regfile: I2C target with an internal byte register file that
// serves one lane (BUS_SEL) of a multi-bus scl/sda vector. It supports
// addressed writes, pointer-based reads, and repeated START. A local port
// preloads and reads back the register file.
// Optional feature macro: I2C_SLV_GLITCH_FILTER_EN adds a 3-sample majority
// filter after each input synchroniser. This suppresses pulses shorter than
// 2 clk and raises the input latency from 2 clk to 4 clk.
module i2c_slave_regfile #(
    parameter int unsigned NUM_I2C_BUSSES = 1,
    parameter int unsigned BUS_SEL        = 0,
    parameter logic [6:0]  SLAVE_ADDR     = 7'h22,
    parameter int unsigned DEPTH          = 16,
    localparam int unsigned PTR_W         = $clog2(DEPTH)
) (
    input  logic                      clk_i,
    input  logic                      rstn_i,
    input  logic [NUM_I2C_BUSSES-1:0] scl_i,
    input  logic [NUM_I2C_BUSSES-1:0] sda_i,
    output logic [NUM_I2C_BUSSES-1:0] scl_o,
    output logic [NUM_I2C_BUSSES-1:0] sda_o,
    input  logic [PTR_W-1:0]          loc_addr_i,
    input  logic                      loc_we_i,
    input  logic [7:0]                loc_wdata_i,
    output logic [7:0]                loc_rdata_o,
    output logic                      busy_o,
    output logic                      wr_done_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_PTR,
        S_WDATA,
        S_RDATA,
        S_IGNORE
    } state_t;

    state_t           state, state_nxt;
    logic [3:0]       bit_cnt, cnt_nxt;
    logic [7:0]       rx, rx_nxt;
    logic [7:0]       tx, tx_nxt;
    logic [PTR_W-1:0] ptr, ptr_nxt;
    logic             sda_drv, sda_nxt;
    logic             busy, busy_nxt;
    logic             wr_done, wr_done_nxt;
    logic             wrote, wrote_nxt;
    logic             rw, rw_nxt;
    logic             mack, mack_nxt;
    logic             i2c_we;

    logic [7:0]       mem [DEPTH];
    logic [7:0]       cur_byte;

    logic [1:0]       scl_sync, sda_sync;
    logic             scl_q, sda_q;
    logic             scl_d, sda_d;
    logic             scl_rise, scl_fall;
    logic             start_det, stop_det;

    // Two-flop synchronisers on the served lane, plus previous-value
    // registers for edge detection. Reset to the idle-bus level.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[0], scl_i[BUS_SEL]};
            sda_sync <= {sda_sync[0], sda_i[BUS_SEL]};
            scl_d    <= scl_q;
            sda_d    <= sda_q;
        end
    end

`ifdef I2C_SLV_GLITCH_FILTER_EN
    logic [1:0] scl_hist, sda_hist;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // Majority vote over the newest synchronised sample and two older ones.
    // A level must be present in two consecutive samples to pass.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            scl_hist <= 2'b11;
            sda_hist <= 2'b11;
            scl_q    <= 1'b1;
            sda_q    <= 1'b1;
        end else begin
            scl_hist <= {scl_hist[0], scl_sync[1]};
            sda_hist <= {sda_hist[0], sda_sync[1]};
            scl_q    <= maj3(scl_sync[1], scl_hist[0], scl_hist[1]);
            sda_q    <= maj3(sda_sync[1], sda_hist[0], sda_hist[1]);
        end
    end
`else
    assign scl_q = scl_sync[1];
    assign sda_q = sda_sync[1];
`endif

    assign scl_rise  = scl_q & ~scl_d;
    assign scl_fall  = ~scl_q & scl_d;
    assign start_det = scl_q & sda_d & ~sda_q;
    assign stop_det  = scl_q & ~sda_d & sda_q;
    assign cur_byte  = mem[ptr];

    // Protocol state register and per-transfer bookkeeping.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state   <= S_IDLE;
            bit_cnt <= '0;
            rx      <= '0;
            tx      <= '0;
            ptr     <= '0;
            sda_drv <= 1'b1;
            busy    <= 1'b0;
            wr_done <= 1'b0;
            wrote   <= 1'b0;
            rw      <= 1'b0;
            mack    <= 1'b1;
        end else begin
            state   <= state_nxt;
            bit_cnt <= cnt_nxt;
            rx      <= rx_nxt;
            tx      <= tx_nxt;
            ptr     <= ptr_nxt;
            sda_drv <= sda_nxt;
            busy    <= busy_nxt;
            wr_done <= wr_done_nxt;
            wrote   <= wrote_nxt;
            rw      <= rw_nxt;
            mack    <= mack_nxt;
        end
    end

    // Next-state logic. Bits are counted on scl rising edges: 1..8 are the
    // data bits, and 9 is the acknowledge clock. sda changes only when a
    // falling edge is detected, so the change lands one clk later.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = bit_cnt;
        rx_nxt      = rx;
        tx_nxt      = tx;
        ptr_nxt     = ptr;
        sda_nxt     = sda_drv;
        busy_nxt    = busy;
        wr_done_nxt = 1'b0;
        wrote_nxt   = wrote;
        rw_nxt      = rw;
        mack_nxt    = mack;
        i2c_we      = 1'b0;

        if (start_det) begin
            state_nxt = S_ADDR;
            cnt_nxt   = '0;
            sda_nxt   = 1'b1;
        end else if (stop_det) begin
            state_nxt   = S_IDLE;
            sda_nxt     = 1'b1;
            busy_nxt    = 1'b0;
            wr_done_nxt = wrote;
            wrote_nxt   = 1'b0;
        end else begin
            case (state)
                S_ADDR, S_PTR, S_WDATA: begin
                    if (scl_rise) begin
                        if (bit_cnt < 4'd8) begin
                            rx_nxt  = {rx[6:0], sda_q};
                            cnt_nxt = bit_cnt + 4'd1;
                        end else if (bit_cnt == 4'd8) begin
                            cnt_nxt = 4'd9;
                        end
                    end else if (scl_fall) begin
                        if (bit_cnt == 4'd8) begin
                            // Byte complete: act on it and pull sda low to acknowledge.
                            sda_nxt = 1'b0;
                            case (state)
                                S_ADDR: begin
                                    if (rx[7:1] == SLAVE_ADDR) begin
                                        busy_nxt = 1'b1;
                                        rw_nxt   = rx[0];
                                    end else begin
                                        sda_nxt   = 1'b1;
                                        state_nxt = S_IGNORE;
                                        cnt_nxt   = '0;
                                    end
                                end
                                S_PTR: ptr_nxt = rx[PTR_W-1:0];
                                default: begin
                                    i2c_we    = 1'b1;
                                    ptr_nxt   = ptr + 1'b1;
                                    wrote_nxt = 1'b1;
                                end
                            endcase
                        end else if (bit_cnt == 4'd9) begin
                            // End of the ack clock: release sda and move on.
                            cnt_nxt = '0;
                            sda_nxt = 1'b1;
                            case (state)
                                S_ADDR: begin
                                    if (rw) begin
                                        state_nxt = S_RDATA;
                                        tx_nxt    = {cur_byte[6:0], 1'b0};
                                        sda_nxt   = cur_byte[7];
                                    end else begin
                                        state_nxt = S_PTR;
                                    end
                                end
                                S_PTR:   state_nxt = S_WDATA;
                                default: state_nxt = state;
                            endcase
                        end
                    end
                end
                S_RDATA: begin
                    if (scl_rise) begin
                        if (bit_cnt < 4'd8) begin
                            cnt_nxt = bit_cnt + 4'd1;
                        end else if (bit_cnt == 4'd8) begin
                            mack_nxt = sda_q;
                            cnt_nxt  = 4'd9;
                        end
                    end else if (scl_fall) begin
                        if (bit_cnt >= 4'd1 && bit_cnt <= 4'd7) begin
                            sda_nxt = tx[7];
                            tx_nxt  = {tx[6:0], 1'b0};
                        end else if (bit_cnt == 4'd8) begin
                            // Byte sent: hand sda to the master for its ack.
                            sda_nxt = 1'b1;
                            ptr_nxt = ptr + 1'b1;
                        end else if (bit_cnt == 4'd9) begin
                            cnt_nxt = '0;
                            if (!mack) begin
                                tx_nxt  = {cur_byte[6:0], 1'b0};
                                sda_nxt = cur_byte[7];
                            end else begin
                                sda_nxt   = 1'b1;
                                state_nxt = S_IGNORE;
                            end
                        end
                    end
                end
                default: state_nxt = state;
            endcase
        end
    end

    // Register file and registered local read port. The I2C write is
    // applied last, so it wins when both ports target the same byte.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
            loc_rdata_o <= '0;
        end else begin
            loc_rdata_o <= mem[loc_addr_i];
            if (loc_we_i) begin
                mem[loc_addr_i] <= loc_wdata_i;
            end
            if (i2c_we) begin
                mem[ptr] <= rx;
            end
        end
    end

    // Open-drain outputs: only the served lane's sda is ever pulled low.
    always_comb begin
        sda_o          = '1;
        sda_o[BUS_SEL] = sda_drv;
    end

    assign scl_o     = '1;
    assign busy_o    = busy;
    assign wr_done_o = wr_done;

endmodule
